stack_ctrl: RTL and testbench

STACK_CTRL -- requirements
Module: stack_ctrl

---
 rtl/stack_ctrl.sv | 141 ++++++++++++++
 tb/tb_stack_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/stack_ctrl.sv
// Byte-wide hardware stack controller: turns push/pop/sp_load commands into
// single memory transactions and keeps the stack pointer and overflow status.
module stack_ctrl #(
    parameter logic [10:0] SP_INIT  = 11'h7FF,
    parameter logic [10:0] SP_LIMIT = 11'h700
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        push,
    input  logic        pop,
    input  logic [7:0]  data_in,
    output logic        ready,
    output logic [7:0]  pop_data,
    output logic        pop_valid,
    input  logic        sp_load,
    input  logic [10:0] sp_load_val,
    output logic        mem_req,
    output logic        mem_we,
    output logic [10:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [10:0] SP,
    output logic        ST_OVF,
    output logic        ST_OVF_en,
    output logic        SP_MSB10,
    output logic        SP_MSB9,
    output logic        SP_MSB8,
    output logic        SP_MSB_en
);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t      state, state_nxt;
    logic [10:0] sp_q, sp_nxt;
    logic        op_push;
    logic        do_load, do_push, do_pop, do_rej, done;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) state <= IDLE;
        else         state <= state_nxt;
    end

    // Command decode; requests arriving outside IDLE are simply not looked at.
    always_comb begin
        state_nxt = state;
        do_load   = 1'b0;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        do_rej    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (sp_load) begin
                    do_load = 1'b1;
                end else if (push) begin
                    if (sp_q >= SP_LIMIT) begin
                        do_push   = 1'b1;
                        state_nxt = ACCESS;
                    end else begin
                        do_rej = 1'b1;
                    end
                end else if (pop) begin
                    if (sp_q < SP_INIT) begin
                        do_pop    = 1'b1;
                        state_nxt = ACCESS;
                    end else begin
                        do_rej = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sp_nxt = sp_q;
        if (do_load)   sp_nxt = sp_load_val;
        else if (done) sp_nxt = op_push ? sp_q - 11'd1 : sp_q + 11'd1;
    end

    // Status strobes default low so each event produces a single-cycle pulse.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            sp_q      <= SP_INIT;
            op_push   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            pop_data  <= '0;
            pop_valid <= 1'b0;
            ST_OVF    <= 1'b0;
            ST_OVF_en <= 1'b0;
            SP_MSB_en <= 1'b0;
        end else begin
            pop_valid <= 1'b0;
            ST_OVF    <= 1'b0;
            ST_OVF_en <= 1'b0;
            SP_MSB_en <= (sp_nxt[10:8] != sp_q[10:8]);
            sp_q      <= sp_nxt;
            if (do_push) begin
                op_push   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= sp_q;
                mem_wdata <= data_in;
            end
            if (do_pop) begin
                op_push  <= 1'b0;
                mem_we   <= 1'b0;
                mem_addr <= sp_q + 11'd1;
            end
            if (do_rej) begin
                ST_OVF    <= 1'b1;
                ST_OVF_en <= 1'b1;
            end
            if (done) begin
                mem_we    <= 1'b0;
                ST_OVF_en <= 1'b1;
                if (!op_push) begin
                    pop_data  <= mem_rdata;
                    pop_valid <= 1'b1;
                end
            end
        end
    end

    // Derived from state so a reset mid-transaction drops the request at once.
    assign mem_req  = (state == ACCESS);
    assign ready    = (state == IDLE);
    assign SP       = sp_q;
    assign SP_MSB10 = sp_q[10];
    assign SP_MSB9  = sp_q[9];
    assign SP_MSB8  = sp_q[8];

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed-vector bench for stack_ctrl: a per-cycle stimulus/expectation table
// followed by hand-written reset-abort sequence.
module tb_stack_ctrl;

    logic        clk = 1'b0;
    logic        reset_;
    logic        push, pop, sp_load, mem_ack;
    logic [7:0]  data_in, mem_rdata;
    logic [10:0] sp_load_val;
    logic        ready, pop_valid, mem_req, mem_we;
    logic [7:0]  pop_data, mem_wdata;
    logic [10:0] mem_addr, SP;
    logic        ST_OVF, ST_OVF_en, SP_MSB10, SP_MSB9, SP_MSB8, SP_MSB_en;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stack_ctrl dut (
        .clk(clk), .reset_(reset_), .push(push), .pop(pop), .data_in(data_in),
        .ready(ready), .pop_data(pop_data), .pop_valid(pop_valid),
        .sp_load(sp_load), .sp_load_val(sp_load_val),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .SP(SP),
        .ST_OVF(ST_OVF), .ST_OVF_en(ST_OVF_en),
        .SP_MSB10(SP_MSB10), .SP_MSB9(SP_MSB9), .SP_MSB8(SP_MSB8), .SP_MSB_en(SP_MSB_en)
    );

    typedef struct {
        logic        push, pop, ld;
        logic [10:0] ldv;
        logic [7:0]  din;
        logic        ack;
        logic [7:0]  rd;
        logic        rdy, req, we;
        logic [10:0] addr;
        logic [7:0]  wd;
        logic [10:0] sp;
        logic        pv;
        logic [7:0]  pd;
        logic        ovf, oen, men;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        push = 0; pop = 0; sp_load = 0; sp_load_val = '0;
        data_in = '0; mem_ack = 0; mem_rdata = '0;
    endtask

    initial begin
        //          push pop ld  ldv     din    ack rd     rdy req we addr    wd     sp      pv pd     ovf oen men
        vecs[0]  = '{1, 0, 0, 11'h000, 8'hA5, 0, 8'h00, 0, 1, 1, 11'h7FF, 8'hA5, 11'h7FF, 0, 8'h00, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 11'h000, 8'h00, 1, 8'h00, 1, 0, 0, 11'h7FF, 8'hA5, 11'h7FE, 0, 8'h00, 0, 1, 0};
        vecs[2]  = '{0, 1, 0, 11'h000, 8'h00, 0, 8'hA5, 0, 1, 0, 11'h7FF, 8'hA5, 11'h7FE, 0, 8'h00, 0, 0, 0};
        vecs[3]  = '{0, 0, 0, 11'h000, 8'h00, 0, 8'hA5, 0, 1, 0, 11'h7FF, 8'hA5, 11'h7FE, 0, 8'h00, 0, 0, 0};
        vecs[4]  = '{0, 0, 0, 11'h000, 8'h00, 0, 8'hA5, 0, 1, 0, 11'h7FF, 8'hA5, 11'h7FE, 0, 8'h00, 0, 0, 0};
        vecs[5]  = '{0, 0, 0, 11'h000, 8'h00, 1, 8'hA5, 1, 0, 0, 11'h7FF, 8'hA5, 11'h7FF, 1, 8'hA5, 0, 1, 0};
        vecs[6]  = '{0, 0, 0, 11'h000, 8'h00, 0, 8'h00, 1, 0, 0, 11'h7FF, 8'hA5, 11'h7FF, 0, 8'hA5, 0, 0, 0};
        vecs[7]  = '{0, 1, 0, 11'h000, 8'h00, 0, 8'h00, 1, 0, 0, 11'h7FF, 8'hA5, 11'h7FF, 0, 8'hA5, 1, 1, 0};
        vecs[8]  = '{0, 0, 0, 11'h000, 8'h00, 0, 8'h00, 1, 0, 0, 11'h7FF, 8'hA5, 11'h7FF, 0, 8'hA5, 0, 0, 0};
        vecs[9]  = '{0, 0, 1, 11'h700, 8'h00, 0, 8'h00, 1, 0, 0, 11'h7FF, 8'hA5, 11'h700, 0, 8'hA5, 0, 0, 0};
        vecs[10] = '{1, 0, 0, 11'h000, 8'h3C, 0, 8'h00, 0, 1, 1, 11'h700, 8'h3C, 11'h700, 0, 8'hA5, 0, 0, 0};
        vecs[11] = '{0, 0, 0, 11'h000, 8'h00, 1, 8'h00, 1, 0, 0, 11'h700, 8'h3C, 11'h6FF, 0, 8'hA5, 0, 1, 1};
        vecs[12] = '{1, 0, 0, 11'h000, 8'h55, 0, 8'h00, 1, 0, 0, 11'h700, 8'h3C, 11'h6FF, 0, 8'hA5, 1, 1, 0};
        vecs[13] = '{1, 1, 1, 11'h7FE, 8'h99, 0, 8'h00, 1, 0, 0, 11'h700, 8'h3C, 11'h7FE, 0, 8'hA5, 0, 0, 1};
        vecs[14] = '{1, 1, 0, 11'h000, 8'h77, 0, 8'h00, 0, 1, 1, 11'h7FE, 8'h77, 11'h7FE, 0, 8'hA5, 0, 0, 0};
        vecs[15] = '{1, 1, 1, 11'h123, 8'h88, 0, 8'h00, 0, 1, 1, 11'h7FE, 8'h77, 11'h7FE, 0, 8'hA5, 0, 0, 0};
        vecs[16] = '{0, 0, 0, 11'h000, 8'h00, 1, 8'h00, 1, 0, 0, 11'h7FE, 8'h77, 11'h7FD, 0, 8'hA5, 0, 1, 0};
        vecs[17] = '{0, 1, 0, 11'h000, 8'h00, 1, 8'h11, 0, 1, 0, 11'h7FE, 8'h77, 11'h7FD, 0, 8'hA5, 0, 0, 0};
        vecs[18] = '{0, 0, 0, 11'h000, 8'h00, 1, 8'h11, 1, 0, 0, 11'h7FE, 8'h77, 11'h7FE, 1, 8'h11, 0, 1, 0};

        idle_inputs();
        reset_ = 1'b0;
        #12;
        chk("rst_ready", ready, 1);
        chk("rst_sp", SP, 11'h7FF);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_flags", {pop_valid, ST_OVF, ST_OVF_en, SP_MSB_en}, 0);
        reset_ = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 19; i++) begin
            push = vecs[i].push; pop = vecs[i].pop; sp_load = vecs[i].ld;
            sp_load_val = vecs[i].ldv; data_in = vecs[i].din;
            mem_ack = vecs[i].ack; mem_rdata = vecs[i].rd;
            @(posedge clk); #1;
            chk($sformatf("v%0d_ready", i), ready, vecs[i].rdy);
            chk($sformatf("v%0d_req", i), mem_req, vecs[i].req);
            chk($sformatf("v%0d_we", i), mem_we, vecs[i].we);
            chk($sformatf("v%0d_addr", i), mem_addr, vecs[i].addr);
            chk($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].wd);
            chk($sformatf("v%0d_sp", i), SP, vecs[i].sp);
            chk($sformatf("v%0d_msbs", i), {SP_MSB10, SP_MSB9, SP_MSB8}, vecs[i].sp[10:8]);
            chk($sformatf("v%0d_pvalid", i), pop_valid, vecs[i].pv);
            chk($sformatf("v%0d_pdata", i), pop_data, vecs[i].pd);
            chk($sformatf("v%0d_ovf", i), ST_OVF, vecs[i].ovf);
            chk($sformatf("v%0d_ovf_en", i), ST_OVF_en, vecs[i].oen);
            chk($sformatf("v%0d_msb_en", i), SP_MSB_en, vecs[i].men);
        end

        // Reset in the middle of a push, then a stale ack after release.
        idle_inputs();
        push = 1; data_in = 8'h42;
        @(posedge clk); #1;
        idle_inputs();
        chk("abort_req_before", mem_req, 1);
        #2 reset_ = 1'b0;
        #1;
        chk("abort_req", mem_req, 0);
        chk("abort_sp", SP, 11'h7FF);
        chk("abort_ready", ready, 1);
        #2 reset_ = 1'b1;
        mem_ack = 1; mem_rdata = 8'hEE;
        @(posedge clk); #1;
        mem_ack = 0;
        chk("late_ack_sp", SP, 11'h7FF);
        chk("late_ack_req", mem_req, 0);
        chk("late_ack_pvalid", pop_valid, 0);
        chk("late_ack_ovf_en", ST_OVF_en, 0);
        chk("late_ack_ready", ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
